lpif_txrx_gearbox: RTL and testbench

LPIF_TXRX_GEARBOX -- requirements
Module: lpif_txrx_gearbox

---
 rtl/lpif_txrx_gearbox.sv | 150 +++++++++++++++
 tb/tb_lpif_txrx_gearbox.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lpif_txrx_gearbox.sv
// LPIF beat <-> FIFO word gearbox: packs RATIO downstream beats into one TX word
// and unpacks RX words into upstream beats. Flush pads (all-zero slots) are skipped.
module lpif_txrx_gearbox #(
  parameter int unsigned RATIO  = 2,
  parameter int unsigned BEAT_W = 42
) (
  input  logic                      lclk,
  input  logic                      rst,
  input  logic [3:0]                dstrm_state,
  input  logic [1:0]                dstrm_protid,
  input  logic [31:0]               dstrm_data,
  input  logic                      dstrm_dvalid,
  input  logic                      dstrm_crc,
  input  logic                      dstrm_crc_valid,
  input  logic                      dstrm_valid,
  input  logic                      dstrm_beat_vld,
  output logic                      dstrm_beat_rdy,
  output logic [RATIO*BEAT_W-1:0]   txfifo_downstream_data,
  output logic                      txfifo_downstream_vld,
  input  logic                      txfifo_downstream_rdy,
  input  logic [RATIO*BEAT_W-1:0]   rxfifo_upstream_data,
  input  logic                      rxfifo_upstream_vld,
  output logic                      rxfifo_upstream_rdy,
  output logic [3:0]                ustrm_state,
  output logic [1:0]                ustrm_protid,
  output logic [31:0]               ustrm_data,
  output logic                      ustrm_dvalid,
  output logic                      ustrm_crc,
  output logic                      ustrm_crc_valid,
  output logic                      ustrm_valid,
  output logic                      ustrm_beat_vld,
  input  logic                      ustrm_beat_rdy,
  input  logic                      tx_flush,
  output logic [1:0]                tx_fill
);

  localparam int unsigned WORD_W = RATIO * BEAT_W;
  localparam logic [1:0]  LAST   = 2'(RATIO - 1);

  logic [BEAT_W-1:0] dstrm_beat;
  logic [BEAT_W-1:0] ustrm_beat;

  logic [WORD_W-1:0] tx_buf_q, tx_buf_d;
  logic [1:0]        tx_fill_q, tx_fill_d;
  logic [WORD_W-1:0] txo_data_q, txo_data_d;
  logic              txo_vld_q, txo_vld_d;
  logic [WORD_W-1:0] tx_word;
  logic              dstrm_accept;
  logic              tx_out_free;
  logic              tx_emit;

  logic [WORD_W-1:0] rx_buf_q, rx_buf_d;
  logic              rx_full_q, rx_full_d;
  logic [1:0]        rx_idx_q, rx_idx_d;
  logic [BEAT_W-1:0] rx_slot;
  logic              rx_pad;
  logic              rx_adv;

  assign dstrm_beat = {dstrm_valid, dstrm_crc_valid, dstrm_crc, dstrm_dvalid,
                       dstrm_data, dstrm_protid, dstrm_state};

  assign dstrm_beat_rdy = !rst && !(txo_vld_q && !txfifo_downstream_rdy && (tx_fill_q == LAST));
  assign dstrm_accept   = dstrm_beat_vld && dstrm_beat_rdy;
  assign tx_out_free    = !txo_vld_q || txfifo_downstream_rdy;

  // Buffer is cleared on every emission so unfilled slots of a flushed word read as zero.
  always_comb begin
    tx_buf_d   = tx_buf_q;
    tx_fill_d  = tx_fill_q;
    txo_data_d = txo_data_q;
    txo_vld_d  = txo_vld_q;
    tx_word    = tx_buf_q;
    if (dstrm_accept) begin
      for (int unsigned k = 0; k < RATIO; k++) begin
        if (32'(tx_fill_q) == k) tx_word[k*BEAT_W +: BEAT_W] = dstrm_beat;
      end
    end
    tx_emit = (dstrm_accept && (tx_fill_q == LAST)) ||
              (tx_flush && (tx_fill_q != 2'd0) && tx_out_free);
    if (txo_vld_q && txfifo_downstream_rdy) txo_vld_d = 1'b0;
    if (tx_emit) begin
      txo_data_d = tx_word;
      txo_vld_d  = 1'b1;
      tx_buf_d   = '0;
      tx_fill_d  = '0;
    end else if (dstrm_accept) begin
      tx_buf_d  = tx_word;
      tx_fill_d = tx_fill_q + 2'd1;
    end
  end

  always_comb begin
    rx_slot = '0;
    for (int unsigned k = 0; k < RATIO; k++) begin
      if (32'(rx_idx_q) == k) rx_slot = rx_buf_q[k*BEAT_W +: BEAT_W];
    end
  end

  assign rx_pad = (rx_idx_q != 2'd0) && (rx_slot == '0);
  assign rx_adv = rx_full_q && (rx_pad || ustrm_beat_rdy);
  assign rxfifo_upstream_rdy = !rst && (!rx_full_q || ((rx_idx_q == LAST) && rx_adv));

  always_comb begin
    rx_buf_d  = rx_buf_q;
    rx_full_d = rx_full_q;
    rx_idx_d  = rx_idx_q;
    if (rx_adv) begin
      if (rx_idx_q == LAST) begin
        rx_full_d = 1'b0;
        rx_idx_d  = '0;
      end else begin
        rx_idx_d = rx_idx_q + 2'd1;
      end
    end
    if (rxfifo_upstream_vld && rxfifo_upstream_rdy) begin
      rx_buf_d  = rxfifo_upstream_data;
      rx_full_d = 1'b1;
      rx_idx_d  = '0;
    end
  end

  always_ff @(posedge lclk) begin
    if (rst) begin
      tx_buf_q   <= '0;
      tx_fill_q  <= '0;
      txo_data_q <= '0;
      txo_vld_q  <= 1'b0;
      rx_buf_q   <= '0;
      rx_full_q  <= 1'b0;
      rx_idx_q   <= '0;
    end else begin
      tx_buf_q   <= tx_buf_d;
      tx_fill_q  <= tx_fill_d;
      txo_data_q <= txo_data_d;
      txo_vld_q  <= txo_vld_d;
      rx_buf_q   <= rx_buf_d;
      rx_full_q  <= rx_full_d;
      rx_idx_q   <= rx_idx_d;
    end
  end

  assign txfifo_downstream_vld  = txo_vld_q && !rst;
  assign txfifo_downstream_data = rst ? '0 : txo_data_q;
  assign tx_fill                = tx_fill_q;
  assign ustrm_beat_vld         = rx_full_q && !rx_pad && !rst;
  assign ustrm_beat             = rst ? '0 : rx_slot;
  assign {ustrm_valid, ustrm_crc_valid, ustrm_crc, ustrm_dvalid,
          ustrm_data, ustrm_protid, ustrm_state} = ustrm_beat;

endmodule

// File: tb/tb_lpif_txrx_gearbox.sv
// Directed and loopback checks of lpif_txrx_gearbox at RATIO 1, 2 and 4.
module tb_lpif_txrx_gearbox;

  logic         lclk = 1'b0;
  logic         rst;
  logic [3:0]   d_state;
  logic [1:0]   d_protid;
  logic [31:0]  d_data;
  logic         d_dvalid, d_crc, d_crcv, d_valid;
  logic         dvld, tx_flush, urdy, loop, link_ok, txr_drv, rxv_drv;
  logic [1:0]   sel;
  logic [167:0] rxd_drv;

  logic         dv[3], drdy[3], txv[3], txr[3], rxv[3], rxr[3], uv[3], fl[3];
  logic [1:0]   fill[3];
  logic [41:0]  ub[3];
  logic [3:0]   u_state[3];
  logic [1:0]   u_protid[3];
  logic [31:0]  u_data[3];
  logic         u_dvalid[3], u_crc[3], u_crcv[3], u_valid[3];
  logic [41:0]  txd1, rxd1;
  logic [83:0]  txd2, rxd2;
  logic [167:0] txd4, rxd4;

  logic         cur_drdy, cur_txv, cur_uv, cur_rxrdy;
  logic [1:0]   cur_fill;
  logic [41:0]  cur_ub;
  logic [167:0] cur_txd;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 lclk = ~lclk;

  for (genvar g = 0; g < 3; g++) begin : g_ctl
    assign dv[g]  = dvld && (sel == 2'(g));
    assign fl[g]  = tx_flush && (sel == 2'(g));
    assign txr[g] = loop ? (rxr[g] && link_ok) : txr_drv;
    assign rxv[g] = loop ? (txv[g] && link_ok) : (rxv_drv && (sel == 2'(g)));
    assign ub[g]  = {u_valid[g], u_crcv[g], u_crc[g], u_dvalid[g], u_data[g], u_protid[g], u_state[g]};
  end

  assign rxd1 = loop ? txd1 : rxd_drv[41:0];
  assign rxd2 = loop ? txd2 : rxd_drv[83:0];
  assign rxd4 = loop ? txd4 : rxd_drv;

  lpif_txrx_gearbox #(.RATIO(1), .BEAT_W(42)) u_r1 (
    .lclk(lclk), .rst(rst),
    .dstrm_state(d_state), .dstrm_protid(d_protid), .dstrm_data(d_data), .dstrm_dvalid(d_dvalid),
    .dstrm_crc(d_crc), .dstrm_crc_valid(d_crcv), .dstrm_valid(d_valid),
    .dstrm_beat_vld(dv[0]), .dstrm_beat_rdy(drdy[0]),
    .txfifo_downstream_data(txd1), .txfifo_downstream_vld(txv[0]), .txfifo_downstream_rdy(txr[0]),
    .rxfifo_upstream_data(rxd1), .rxfifo_upstream_vld(rxv[0]), .rxfifo_upstream_rdy(rxr[0]),
    .ustrm_state(u_state[0]), .ustrm_protid(u_protid[0]), .ustrm_data(u_data[0]), .ustrm_dvalid(u_dvalid[0]),
    .ustrm_crc(u_crc[0]), .ustrm_crc_valid(u_crcv[0]), .ustrm_valid(u_valid[0]),
    .ustrm_beat_vld(uv[0]), .ustrm_beat_rdy(urdy),
    .tx_flush(fl[0]), .tx_fill(fill[0]));

  lpif_txrx_gearbox #(.RATIO(2), .BEAT_W(42)) u_r2 (
    .lclk(lclk), .rst(rst),
    .dstrm_state(d_state), .dstrm_protid(d_protid), .dstrm_data(d_data), .dstrm_dvalid(d_dvalid),
    .dstrm_crc(d_crc), .dstrm_crc_valid(d_crcv), .dstrm_valid(d_valid),
    .dstrm_beat_vld(dv[1]), .dstrm_beat_rdy(drdy[1]),
    .txfifo_downstream_data(txd2), .txfifo_downstream_vld(txv[1]), .txfifo_downstream_rdy(txr[1]),
    .rxfifo_upstream_data(rxd2), .rxfifo_upstream_vld(rxv[1]), .rxfifo_upstream_rdy(rxr[1]),
    .ustrm_state(u_state[1]), .ustrm_protid(u_protid[1]), .ustrm_data(u_data[1]), .ustrm_dvalid(u_dvalid[1]),
    .ustrm_crc(u_crc[1]), .ustrm_crc_valid(u_crcv[1]), .ustrm_valid(u_valid[1]),
    .ustrm_beat_vld(uv[1]), .ustrm_beat_rdy(urdy),
    .tx_flush(fl[1]), .tx_fill(fill[1]));

  lpif_txrx_gearbox #(.RATIO(4), .BEAT_W(42)) u_r4 (
    .lclk(lclk), .rst(rst),
    .dstrm_state(d_state), .dstrm_protid(d_protid), .dstrm_data(d_data), .dstrm_dvalid(d_dvalid),
    .dstrm_crc(d_crc), .dstrm_crc_valid(d_crcv), .dstrm_valid(d_valid),
    .dstrm_beat_vld(dv[2]), .dstrm_beat_rdy(drdy[2]),
    .txfifo_downstream_data(txd4), .txfifo_downstream_vld(txv[2]), .txfifo_downstream_rdy(txr[2]),
    .rxfifo_upstream_data(rxd4), .rxfifo_upstream_vld(rxv[2]), .rxfifo_upstream_rdy(rxr[2]),
    .ustrm_state(u_state[2]), .ustrm_protid(u_protid[2]), .ustrm_data(u_data[2]), .ustrm_dvalid(u_dvalid[2]),
    .ustrm_crc(u_crc[2]), .ustrm_crc_valid(u_crcv[2]), .ustrm_valid(u_valid[2]),
    .ustrm_beat_vld(uv[2]), .ustrm_beat_rdy(urdy),
    .tx_flush(fl[2]), .tx_fill(fill[2]));

  always_comb begin
    cur_drdy  = drdy[sel];
    cur_txv   = txv[sel];
    cur_uv    = uv[sel];
    cur_rxrdy = rxr[sel];
    cur_fill  = fill[sel];
    cur_ub    = ub[sel];
    cur_txd   = '0;
    case (sel)
      2'd0:    cur_txd[41:0] = txd1;
      2'd1:    cur_txd[83:0] = txd2;
      default: cur_txd       = txd4;
    endcase
  end

  task automatic check(input string tag, input logic [167:0] got, input logic [167:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge lclk);
    #1;
  endtask

  function automatic logic [41:0] mkbeat(input logic [31:0] d);
    return {1'b1, d[0], d[1], 1'b1, d, d[5:4], d[3:0]};
  endfunction

  task automatic drive_beat(input logic [41:0] b);
    {d_valid, d_crcv, d_crc, d_dvalid, d_data, d_protid, d_state} = b;
  endtask

  task automatic loopback(input logic [1:0] s, input int n);
    logic [41:0] sb[$];
    logic [41:0] b, exp;
    int sent = 0;
    int rcvd = 0;
    int cyc  = 0;
    sel = s;
    loop = 1'b1;
    b = mkbeat($urandom);
    while (rcvd < n && cyc < 3000) begin
      dvld     = (sent < n) && ($urandom_range(0, 3) != 0);
      link_ok  = ($urandom_range(0, 3) != 0);
      urdy     = ($urandom_range(0, 2) != 0);
      tx_flush = (sent == n) || ($urandom_range(0, 7) == 0);
      drive_beat(b);
      #1;
      if (dvld && cur_drdy) begin
        sb.push_back(b);
        sent++;
        b = mkbeat($urandom);
      end
      if (cur_uv && urdy) begin
        rcvd++;
        exp = (sb.size() != 0) ? sb.pop_front() : '1;
        check($sformatf("lb_r%0d_beat%0d", s, rcvd), 168'(cur_ub), 168'(exp));
      end
      tick();
      cyc++;
    end
    dvld = 1'b0; tx_flush = 1'b0; loop = 1'b0; link_ok = 1'b1; urdy = 1'b0;
    check($sformatf("lb_r%0d_count", s), 168'(rcvd), 168'(n));
    check($sformatf("lb_r%0d_sent", s), 168'(sent), 168'(n));
  endtask

  logic [31:0] nxt;
  int          got;

  initial begin
    rst = 1'b1; dvld = 1'b0; tx_flush = 1'b0; urdy = 1'b0; loop = 1'b0; link_ok = 1'b1;
    txr_drv = 1'b1; rxv_drv = 1'b0; rxd_drv = '0; sel = 2'd0;
    drive_beat('0);
    repeat (2) tick();

    // Reset state on all three ratios
    for (int s = 0; s < 3; s++) begin
      sel = 2'(s);
      #1;
      check($sformatf("rst_drdy_r%0d", s), 168'(cur_drdy), 168'(0));
      check($sformatf("rst_rxrdy_r%0d", s), 168'(cur_rxrdy), 168'(0));
      check($sformatf("rst_txv_r%0d", s), 168'(cur_txv), 168'(0));
      check($sformatf("rst_uv_r%0d", s), 168'(cur_uv), 168'(0));
      check($sformatf("rst_fill_r%0d", s), 168'(cur_fill), 168'(0));
    end
    tick();

    // RATIO=2 basic pack
    rst = 1'b0; sel = 2'd1; txr_drv = 1'b1;
    drive_beat(mkbeat(32'hA)); dvld = 1'b1;
    #1;
    check("t1_first_rdy", 168'(cur_drdy), 168'(1));
    tick();
    check("t1_fill1", 168'(cur_fill), 168'(1));
    check("t1_txv_early", 168'(cur_txv), 168'(0));
    drive_beat(mkbeat(32'hB));
    tick();
    dvld = 1'b0;
    check("t1_txv", 168'(cur_txv), 168'(1));
    check("t1_data_a", 168'(cur_txd[37:6]), 168'(32'hA));
    check("t1_data_b", 168'(cur_txd[79:48]), 168'(32'hB));
    check("t1_word", cur_txd, 168'({mkbeat(32'hB), mkbeat(32'hA)}));
    check("t1_fill0", 168'(cur_fill), 168'(0));
    tick();
    check("t1_drained", 168'(cur_txv), 168'(0));

    // RATIO=4 backpressure: 4 packed + 3 held, then stall
    sel = 2'd2; txr_drv = 1'b0; nxt = 32'd1;
    for (int c = 0; c < 10; c++) begin
      drive_beat(mkbeat(nxt)); dvld = 1'b1;
      #1;
      if (cur_drdy) nxt++;
      tick();
    end
    check("t2_accepted", 168'(nxt), 168'(8));
    check("t2_stall_rdy", 168'(cur_drdy), 168'(0));
    check("t2_fill3", 168'(cur_fill), 168'(3));
    check("t2_word1", cur_txd, {mkbeat(32'd4), mkbeat(32'd3), mkbeat(32'd2), mkbeat(32'd1)});
    txr_drv = 1'b1;
    #1;
    check("t2_drain_rdy", 168'(cur_drdy), 168'(1));
    tick();
    dvld = 1'b0;
    check("t2_b2b_vld", 168'(cur_txv), 168'(1));
    check("t2_word2", cur_txd, {mkbeat(32'd8), mkbeat(32'd7), mkbeat(32'd6), mkbeat(32'd5)});
    check("t2_fill0", 168'(cur_fill), 168'(0));
    tick();
    check("t2_idle", 168'(cur_txv), 168'(0));

    // RATIO=4 single beat + flush, looped back to RX
    loop = 1'b1; link_ok = 1'b1; urdy = 1'b1;
    drive_beat(mkbeat(32'h55)); dvld = 1'b1;
    tick();
    dvld = 1'b0;
    check("t3_fill1", 168'(cur_fill), 168'(1));
    tx_flush = 1'b1;
    tick();
    tx_flush = 1'b0;
    check("t3_txv", 168'(cur_txv), 168'(1));
    check("t3_word", cur_txd, 168'(mkbeat(32'h55)));
    check("t3_fill0", 168'(cur_fill), 168'(0));
    got = 0;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (cur_uv) begin
        got++;
        check("t3_rx_beat", 168'(cur_ub), 168'(mkbeat(32'h55)));
      end
      tick();
    end
    check("t3_rx_count", 168'(got), 168'(1));
    check("t3_rx_empty", 168'(cur_rxrdy), 168'(1));
    loop = 1'b0; urdy = 1'b0;

    // RATIO=2 RX unpack with toggling ustrm_beat_rdy
    sel = 2'd1;
    rxd_drv = '0; rxd_drv[83:0] = {mkbeat(32'h222), mkbeat(32'h111)}; rxv_drv = 1'b1;
    #1;
    check("t4_rxrdy_empty", 168'(cur_rxrdy), 168'(1));
    tick();
    rxv_drv = 1'b0; urdy = 1'b1;
    #1;
    check("t4_s0_vld", 168'(cur_uv), 168'(1));
    check("t4_s0_beat", 168'(cur_ub), 168'(mkbeat(32'h111)));
    check("t4_s0_rxrdy", 168'(cur_rxrdy), 168'(0));
    tick();
    urdy = 1'b0;
    #1;
    check("t4_s1_vld", 168'(cur_uv), 168'(1));
    check("t4_s1_beat_wait", 168'(cur_ub), 168'(mkbeat(32'h222)));
    check("t4_s1_rxrdy_wait", 168'(cur_rxrdy), 168'(0));
    tick();
    urdy = 1'b1;
    #1;
    check("t4_s1_beat", 168'(cur_ub), 168'(mkbeat(32'h222)));
    check("t4_s1_rxrdy_take", 168'(cur_rxrdy), 168'(1));
    tick();
    urdy = 1'b0;
    #1;
    check("t4_done_vld", 168'(cur_uv), 168'(0));

    // RATIO=2 reset mid-traffic
    txr_drv = 1'b1;
    drive_beat(mkbeat(32'h77)); dvld = 1'b1;
    rxd_drv[83:0] = {mkbeat(32'h99), mkbeat(32'h88)}; rxv_drv = 1'b1;
    tick();
    dvld = 1'b0; rxv_drv = 1'b0; urdy = 1'b1;
    tick();
    urdy = 1'b0;
    #1;
    check("t5_pre_fill", 168'(cur_fill), 168'(1));
    check("t5_pre_uv", 168'(cur_uv), 168'(1));
    check("t5_pre_beat", 168'(cur_ub), 168'(mkbeat(32'h99)));
    rst = 1'b1;
    tick();
    check("t5_rst_txv", 168'(cur_txv), 168'(0));
    check("t5_rst_uv", 168'(cur_uv), 168'(0));
    check("t5_rst_fill", 168'(cur_fill), 168'(0));
    check("t5_rst_drdy", 168'(cur_drdy), 168'(0));
    check("t5_rst_rxrdy", 168'(cur_rxrdy), 168'(0));
    check("t5_rst_ubeat", 168'(cur_ub), 168'(0));
    rst = 1'b0;
    drive_beat(mkbeat(32'hC1)); dvld = 1'b1;
    #1;
    check("t5_post_rdy", 168'(cur_drdy), 168'(1));
    tick();
    drive_beat(mkbeat(32'hC2));
    tick();
    dvld = 1'b0;
    check("t5_post_txv", 168'(cur_txv), 168'(1));
    check("t5_post_word", cur_txd, 168'({mkbeat(32'hC2), mkbeat(32'hC1)}));
    check("t5_post_uv", 168'(cur_uv), 168'(0));
    tick();

    // Random handshake loopback, all ratios
    loopback(2'd0, 40);
    loopback(2'd1, 40);
    loopback(2'd2, 40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
